// File: rtl/freq_div_ctrl.sv
// Programmable 50%-duty clock divider (ratio 2*H) with start/clean-stop control
// and a single-entry configuration buffer applied only at safe boundaries.
module freq_div_ctrl #(
  parameter int unsigned W            = 5,
  parameter int unsigned DEFAULT_HALF = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_half,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         freq_out,
  output logic         tick,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] h_act_q, h_act_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_v_q, pend_v_d;
  logic         freq_d, tick_d, err_d;
  logic         last;
  logic         accept;

  assign cfg_ready = ~pend_v_q;
  assign busy      = (state_q != IDLE);
  assign accept    = cfg_valid & ~pend_v_q;
  // >= keeps a phase terminating even if H_act shrinks below cnt while stopping
  assign last      = (cnt_q >= (h_act_q - W'(1)));

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    h_act_d  = h_act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    freq_d   = freq_out;
    tick_d   = 1'b0;
    err_d    = 1'b0;

    if (accept) begin
      if (cfg_half == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d   = cfg_half;
        pend_v_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        freq_d = 1'b0;
        cnt_d  = '0;
        if (pend_v_q) begin
          h_act_d  = pend_q;
          pend_v_d = 1'b0;
        end
        if (start && !stop) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop && !freq_out) begin
          state_d = IDLE;
          freq_d  = 1'b0;
          cnt_d   = '0;
        end else if (last) begin
          cnt_d  = '0;
          freq_d = ~freq_out;
          tick_d = ~freq_out;
          // Falling edge is the period boundary: safe point to swap H
          if (freq_out) begin
            if (pend_v_q) begin
              h_act_d  = pend_q;
              pend_v_d = 1'b0;
            end
            if (stop) begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + W'(1);
          if (stop) begin
            state_d = STOPPING;
          end
        end
      end

      STOPPING: begin
        if (pend_v_q) begin
          h_act_d  = pend_q;
          pend_v_d = 1'b0;
        end
        if (last) begin
          freq_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        freq_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      h_act_q  <= W'(DEFAULT_HALF);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      freq_out <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      h_act_q  <= h_act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      freq_out <= freq_d;
      tick     <= tick_d;
      cfg_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: directed scenarios then random traffic, checked every
// cycle against a position-in-period reference model.
module tb_freq_div_ctrl;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst, start, stop, cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready, cfg_err, freq_out, tick, busy;

  int checks = 0;
  int errors = 0;

  // Model: pos is the position within a 2*h period; level high when pos >= h
  bit m_busy, m_stopping, m_pv, m_err;
  int m_pos, m_h, m_ph;

  always #5 clk = ~clk;

  freq_div_ctrl #(.W(W), .DEFAULT_HALF(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_half(cfg_half), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .freq_out(freq_out), .tick(tick), .busy(busy)
  );

  function automatic bit exp_freq();
    return m_busy && (m_pos >= m_h);
  endfunction

  function automatic bit exp_tick();
    return m_busy && (m_pos == m_h);
  endfunction

  task automatic model_update(input bit r, input bit s, input bit p,
                              input bit cv, input int ch);
    bit acc;
    if (r) begin
      m_busy = 0; m_stopping = 0; m_pv = 0; m_err = 0;
      m_pos = 0; m_h = 3; m_ph = 0;
      return;
    end
    acc   = cv && !m_pv;
    m_err = acc && (ch == 0);
    if (!m_busy) begin
      if (m_pv) begin m_h = m_ph; m_pv = 0; end
      if (s && !p) begin m_busy = 1; m_stopping = 0; m_pos = 0; end
    end else if (!m_stopping) begin
      if (p && (m_pos < m_h)) begin
        m_busy = 0; m_pos = 0;
      end else if (m_pos == 2*m_h - 1) begin
        m_pos = 0;
        if (m_pv) begin m_h = m_ph; m_pv = 0; end
        if (p) m_busy = 0;
      end else begin
        m_pos++;
        if (p) m_stopping = 1;
      end
    end else begin
      if (m_pos >= 2*m_h - 1) begin
        m_busy = 0; m_stopping = 0; m_pos = 0;
        if (m_pv) begin m_h = m_ph; m_pv = 0; end
      end else begin
        m_pos++;
        // keep elapsed high time when H changes mid-phase
        if (m_pv) begin m_pos = m_pos - m_h + m_ph; m_h = m_ph; m_pv = 0; end
      end
    end
    if (acc && ch != 0) begin m_pv = 1; m_ph = ch; end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p, input bit cv, input int ch);
    rst = r; start = s; stop = p; cfg_valid = cv; cfg_half = W'(ch);
    @(posedge clk);
    model_update(r, s, p, cv, ch);
    #1;
    check1("freq_out",  freq_out,  exp_freq());
    check1("tick",      tick,      exp_tick());
    check1("busy",      busy,      m_busy);
    check1("cfg_ready", cfg_ready, !m_pv);
    check1("cfg_err",   cfg_err,   m_err);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; cfg_valid = 0; cfg_half = '0;
    m_busy = 0; m_stopping = 0; m_pv = 0; m_err = 0; m_pos = 0; m_h = 3; m_ph = 0;

    // reset, then start at default divide-by-6
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 7);
    idle_steps(2);
    step(0, 1, 0, 0, 0);
    idle_steps(14);

    // new H=5 offered in the middle of a high phase
    for (int i = 0; i < 20 && !(m_busy && m_pos == m_h + 1); i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5);
    idle_steps(25);

    // stop during the second high cycle
    for (int i = 0; i < 30 && !(m_busy && m_pos == m_h + 1); i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle_steps(8);

    // stop during the low phase
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle_steps(8);

    // zero half-period rejected while running
    step(0, 1, 0, 0, 0);
    idle_steps(3);
    step(0, 0, 0, 1, 0);
    idle_steps(15);

    // H=1 divide-by-2, then start+stop together in IDLE
    step(0, 0, 0, 1, 1);
    idle_steps(12);
    step(0, 0, 1, 0, 0);
    idle_steps(6);
    step(0, 1, 0, 0, 0);
    idle_steps(10);
    step(0, 0, 1, 0, 0);
    idle_steps(3);
    step(0, 1, 1, 0, 0);
    idle_steps(4);

    // reset mid-high phase with a configuration pending
    step(0, 0, 0, 1, 4);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 20 && !(m_busy && m_pos == m_h + 1); i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6);
    step(1, 0, 0, 0, 0);
    idle_steps(3);
    step(0, 1, 0, 0, 0);
    idle_steps(12);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 23) == 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 SHALL have parameter W, default 5, width of the half-period count.
REQ-002 SHALL have parameter DEFAULT_HALF, default 3, half-period loaded at reset (divide-by-6).
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  pulse; begin dividing.
REQ-006 SHALL have port stop  input  1  pulse; request clean stop.
REQ-007 SHALL have port cfg_valid  input  1  new half-period offered.
REQ-008 SHALL have port cfg_half  input  W  requested half-period H; divide ratio is 2H.
REQ-009 SHALL have port cfg_ready  output  1  the block can accept a configuration.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse when an accepted cfg_half is 0.
REQ-011 SHALL have port freq_out  output  1  divided output, registered, 50% duty.
REQ-012 SHALL have port tick  output  1  one-cycle pulse in the cycle freq_out goes 0->1.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, RUN and STOPPING; busy = (state != IDLE).
REQ-015 SHALL hold freq_out=0 and cnt=0 in IDLE.
REQ-016 SHALL move IDLE->RUN on start; freq_out is low for H cycles from the first RUN cycle, then high for H cycles, and repeats.
REQ-017 SHALL count with cnt over 0..H_act-1; at cnt==H_act-1 it toggles freq_out and clears cnt; H_act is the W-bit active half-period.
REQ-018 SHALL drive tick high for exactly the first cycle in which freq_out=1 of each high phase.
REQ-019 SHALL accept a configuration on the handshake cfg_valid & cfg_ready into a single pending register; cfg_ready = ~pending_valid.
REQ-020 SHALL reject an accepted cfg_half==0: cfg_err pulses the next cycle, the pending register stays empty and H_act is unchanged.
REQ-021 SHALL apply a pending H in RUN only at the period boundary (the cycle freq_out toggles 1->0): H_act<=pending, cnt<=0, pending cleared.
REQ-022 SHALL apply a pending H in IDLE or STOPPING on the next clock edge.
REQ-023 SHALL never produce an output phase shorter than min(old H, new H) cycles as a result of a configuration change.
REQ-024 SHALL handle stop in RUN as follows: with freq_out=0, go to IDLE next cycle (low phase truncated); with freq_out=1, go to STOPPING.
REQ-025 SHALL in STOPPING complete the current high phase, then set freq_out<=0, cnt<=0 and go to IDLE; start is ignored in STOPPING.
REQ-026 SHALL give priority to stop when start and stop are asserted together (IDLE stays IDLE; RUN handles stop).
REQ-027 SHALL ignore start in RUN and ignore stop in IDLE.
REQ-028 SHALL support H=1, giving divide-by-2: freq_out toggles every cycle and tick asserts every other cycle.
REQ-029 SHALL treat H_act, once set, as unchanged across start/stop cycles.

Reset
REQ-030 SHALL on rst: state=IDLE, freq_out=0, tick=0, cnt=0, H_act=DEFAULT_HALF, pending empty, cfg_ready=1, cfg_err=0, busy=0.
REQ-031 SHALL have rst override all other inputs; rst mid-RUN forces freq_out=0 on the next edge.

Verification
REQ-032 SHALL cover: reset, then start pulse -> freq_out 000111 repeating (period 6), tick once per period, busy=1.
REQ-033 SHALL cover: in RUN with H=3, cfg_half=5 accepted mid-high phase -> current period finishes at 6 cycles, then 5 low/5 high; cfg_ready low until applied.
REQ-034 SHALL cover: stop during the 2nd high cycle -> freq_out stays high for 1 more cycle, drops, busy=0 in the same cycle as the drop; stop during low -> IDLE next cycle, no high pulse.
REQ-035 SHALL cover: cfg_half=0 offered -> cfg_err pulse 1 cycle, period unchanged, cfg_ready stays 1.
REQ-036 SHALL cover: H=1 -> freq_out 0101..., tick on every rising cycle; start+stop together in IDLE -> remains IDLE.
REQ-037 SHALL cover: rst asserted mid-high phase -> next cycle freq_out=0, H_act=3, pending cleared.
